mat4x4_serializer: RTL and testbench

Result-side serializer for the 4x4 matrix multiplier. It accepts one 512-bit packed 4x4 matrix of 32-bit elements through the multiplier's output handshake, acting as the consumer that drives the multiplier's accept input. It then streams the 16 elements out one word at a time over a valid/ready interface, feeding the narrow back end of the ZF detector datapath (write-back, CORDIC/divider stages).

---
 rtl/zf_mat_pkg.sv | 17 +
 rtl/mat4x4_elem_sel.sv | 31 +++
 rtl/mat4x4_serializer.sv | 72 +++++++
 tb/tb_mat4x4_serializer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/zf_mat_pkg.sv
// Shared definitions for the ZF detector 4x4 matrix datapath.
package zf_mat_pkg;

   localparam int MAT_N  = 4;
   localparam int ELEM_W = 32;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } mat_state_e;

   // LSB position of element [r][c] in a packed matrix; [0][0] sits in the MSBs.
   function automatic int elem_lsb(input int r, input int c, input int dw = ELEM_W);
      return MAT_N*MAT_N*dw - dw*(MAT_N*r + c + 1);
   endfunction

endpackage

// File: rtl/mat4x4_elem_sel.sv
// Combinational 16:1 element mux: element counter -> (row, col) -> word.
module mat4x4_elem_sel
   import zf_mat_pkg::*;
#(
   parameter int DATA_W    = ELEM_W,
   parameter bit COL_MAJOR = 1'b0
) (
   input  logic [16*DATA_W-1:0] i_buf,
   input  logic [3:0]           i_cnt,
   output logic [DATA_W-1:0]    o_word,
   output logic [1:0]           o_row,
   output logic [1:0]           o_col
);

   logic [DATA_W-1:0] w_elem [16];
   logic [1:0]        w_row;
   logic [1:0]        w_col;

   // Unpack the flat buffer into row-major element slots.
   for (genvar g = 0; g < 16; g++) begin : g_elem
      assign w_elem[g] = i_buf[elem_lsb(g / 4, g % 4, DATA_W) +: DATA_W];
   end

   // Column-major walks down a column first, so the low counter bits pick the row.
   assign w_row  = COL_MAJOR ? i_cnt[1:0] : i_cnt[3:2];
   assign w_col  = COL_MAJOR ? i_cnt[3:2] : i_cnt[1:0];
   assign o_word = w_elem[{w_row, w_col}];
   assign o_row  = w_row;
   assign o_col  = w_col;

endmodule

// File: rtl/mat4x4_serializer.sv
// Captures one packed 4x4 matrix from the multiplier and streams its 16
// elements one word per transfer over a valid/ready interface.
module mat4x4_serializer
   import zf_mat_pkg::*;
#(
   parameter int DATA_W    = ELEM_W,
   parameter bit COL_MAJOR = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ready_in,
   input  logic [16*DATA_W-1:0] mat_in,
   output logic                 accept_out,
   output logic [DATA_W-1:0]    word_out,
   output logic                 valid_out,
   input  logic                 word_ready_in,
   output logic [1:0]           row_out,
   output logic [1:0]           col_out,
   output logic                 last_out
);

   localparam logic [0:0] S_IDLE   = ST_IDLE;
   localparam logic [0:0] S_STREAM = ST_STREAM;

   logic [0:0]           r_state;
   logic [3:0]           r_cnt;
   logic [16*DATA_W-1:0] r_buf;
   logic                 w_xfer;

   assign valid_out  = (r_state == S_STREAM);
   // Held low during reset so the multiplier never hands off into a clearing buffer.
   assign accept_out = (r_state == S_IDLE) && !reset;
   assign w_xfer     = valid_out && word_ready_in;
   assign last_out   = valid_out && (r_cnt == 4'd15);

   // FSM, element counter and matrix buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_buf   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ready_in) begin
                  r_buf   <= mat_in;
                  r_cnt   <= 4'd0;
                  r_state <= S_STREAM;
               end
            end
            default: begin
               if (w_xfer) begin
                  r_cnt <= r_cnt + 4'd1;
                  if (r_cnt == 4'd15) r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   mat4x4_elem_sel #(
      .DATA_W    (DATA_W),
      .COL_MAJOR (COL_MAJOR)
   ) u_sel (
      .i_buf  (r_buf),
      .i_cnt  (r_cnt),
      .o_word (word_out),
      .o_row  (row_out),
      .o_col  (col_out)
   );

endmodule

// File: tb/tb_mat4x4_serializer.sv
// Scoreboard bench: row-major and column-major instances share stimulus; each
// has its own expected-word queue and monitor.
module tb_mat4x4_serializer;

   typedef struct {
      logic [31:0] word;
      logic [1:0]  row;
      logic [1:0]  col;
      logic        last;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         ready_in = 1'b0;
   logic [511:0] mat_in = '0;
   logic         word_ready_in = 1'b0;

   logic        a_accept, a_valid, a_last, b_accept, b_valid, b_last;
   logic [31:0] a_word, b_word;
   logic [1:0]  a_row, a_col, b_row, b_col;

   int checks = 0;
   int errors = 0;

   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;

   mat4x4_serializer #(.DATA_W(32), .COL_MAJOR(1'b0)) dut_row (
      .clk(clk), .reset(reset), .ready_in(ready_in), .mat_in(mat_in),
      .accept_out(a_accept), .word_out(a_word), .valid_out(a_valid),
      .word_ready_in(word_ready_in), .row_out(a_row), .col_out(a_col), .last_out(a_last)
   );

   mat4x4_serializer #(.DATA_W(32), .COL_MAJOR(1'b1)) dut_col (
      .clk(clk), .reset(reset), .ready_in(ready_in), .mat_in(mat_in),
      .accept_out(b_accept), .word_out(b_word), .valid_out(b_valid),
      .word_ready_in(word_ready_in), .row_out(b_row), .col_out(b_col), .last_out(b_last)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [511:0] mk(input int kind);
      logic [511:0] m;
      m = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            case (kind)
               0: m[511-128*r-32*c -: 32] = 32'h100 * r + c;
               1: m[511-128*r-32*c -: 32] = 32'hDEAD0000 | (r << 4) | c;
               default: m[511-128*r-32*c -: 32] = 32'hFFFFFFFF;
            endcase
      return m;
   endfunction

   task automatic push_exp(input logic [511:0] m);
      exp_t e;
      int r, c;
      for (int i = 0; i < 16; i++) begin
         r = i / 4; c = i % 4;
         e.word = m[511-128*r-32*c -: 32]; e.row = 2'(r); e.col = 2'(c); e.last = (i == 15);
         q_a.push_back(e);
         r = i % 4; c = i / 4;
         e.word = m[511-128*r-32*c -: 32]; e.row = 2'(r); e.col = 2'(c); e.last = (i == 15);
         q_b.push_back(e);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present a matrix for one edge; returns in the first output cycle.
   task automatic capture(input logic [511:0] m);
      mat_in   = m;
      ready_in = 1'b1;
      push_exp(m);
      tick(1);
      ready_in = 1'b0;
      mat_in   = '0;
   endtask

   // Row-major monitor: pop on transfer, hold check across stalls.
   logic        stall_a = 1'b0;
   logic [36:0] held_a;
   exp_t        e_a;
   always @(negedge clk) begin
      if (reset) stall_a = 1'b0;
      else begin
         if (stall_a) chk("row_stall_hold", {27'd0, a_word, a_row, a_col, a_last}, {27'd0, held_a});
         if (a_valid && word_ready_in) begin
            if (q_a.size() == 0) chk("row_unexpected_word", {32'd0, a_word}, 64'hDEAD);
            else begin
               e_a = q_a.pop_front();
               chk("row_word", {32'd0, a_word}, {32'd0, e_a.word});
               chk("row_rc_last", {59'd0, a_row, a_col, a_last}, {59'd0, e_a.row, e_a.col, e_a.last});
            end
            stall_a = 1'b0;
         end else if (a_valid) begin
            stall_a = 1'b1;
            held_a  = {a_word, a_row, a_col, a_last};
         end else stall_a = 1'b0;
      end
   end

   // Column-major monitor.
   logic        stall_b = 1'b0;
   logic [36:0] held_b;
   exp_t        e_b;
   always @(negedge clk) begin
      if (reset) stall_b = 1'b0;
      else begin
         if (stall_b) chk("col_stall_hold", {27'd0, b_word, b_row, b_col, b_last}, {27'd0, held_b});
         if (b_valid && word_ready_in) begin
            if (q_b.size() == 0) chk("col_unexpected_word", {32'd0, b_word}, 64'hDEAD);
            else begin
               e_b = q_b.pop_front();
               chk("col_word", {32'd0, b_word}, {32'd0, e_b.word});
               chk("col_rc_last", {59'd0, b_row, b_col, b_last}, {59'd0, e_b.row, e_b.col, e_b.last});
            end
            stall_b = 1'b0;
         end else if (b_valid) begin
            stall_b = 1'b1;
            held_b  = {b_word, b_row, b_col, b_last};
         end else stall_b = 1'b0;
      end
   end

   initial begin
      int n;
      // Reset and idle
      tick(2);
      chk("accept_in_reset", {63'd0, a_accept}, 64'd0);
      reset = 1'b0;
      tick(1);
      chk("rst_accept", {62'd0, a_accept, b_accept}, 64'd3);
      chk("rst_valid", {62'd0, a_valid, b_valid}, 64'd0);
      chk("rst_word", {a_word, b_word}, 64'd0);
      chk("rst_rc_last", {56'd0, a_row, a_col, b_row, b_col}, {63'd0, a_last | b_last});
      for (int i = 0; i < 10; i++) begin
         mat_in = {16{$urandom()}};
         tick(1);
         chk("idle_hold", {60'd0, a_accept, b_accept, a_valid, b_valid}, 64'hC);
      end
      chk("idle_word", {a_word, b_word}, 64'd0);

      // Row/column stream with word_ready_in held high
      word_ready_in = 1'b1;
      capture(mk(0));
      chk("first_word_row", {32'd0, a_word}, 64'h000);
      chk("first_valid", {60'd0, a_valid, b_valid, a_accept, b_accept}, 64'hC);
      tick(1);
      chk("second_word_row", {32'd0, a_word}, 64'h001);
      chk("second_word_col", {32'd0, b_word}, 64'h100);
      tick(14);
      chk("last_at_k16", {62'd0, a_last, b_last}, 64'd3);
      chk("word_at_k16", {a_word, b_word}, {32'h303, 32'h303});
      tick(1);
      chk("accept_at_k17", {60'd0, a_accept, b_accept, a_valid, b_valid}, 64'hC);

      // Backpressure
      capture(mk(1));
      n = 0;
      while ((a_valid || b_valid) && n < 400) begin
         word_ready_in = 1'($urandom_range(0, 1));
         tick(1);
         n++;
      end
      word_ready_in = 1'b1;
      chk("bp_timeout", {63'd0, n >= 400}, 64'd0);
      tick(1);
      chk("bp_drained", {32'(q_a.size()), 32'(q_b.size())}, 64'd0);

      // Upstream held with mat_in changing mid-stream
      mat_in = mk(0);
      ready_in = 1'b1;
      push_exp(mk(0));
      tick(1);
      tick(5);
      mat_in = mk(2);
      push_exp(mk(2));
      tick(11);
      chk("hold_accept_k17", {63'd0, a_accept}, 64'd1);
      tick(1);
      ready_in = 1'b0;
      chk("hold_second_capture", {30'd0, a_valid, a_accept, a_word}, {30'd0, 2'b10, 32'hFFFFFFFF});
      tick(16);
      chk("hold_done", {62'd0, a_accept, a_valid}, 64'd2);

      // Reset mid-stream
      capture(mk(1));
      tick(5);
      reset = 1'b1;
      q_a.delete();
      q_b.delete();
      tick(1);
      chk("midrst_valid", {60'd0, a_valid, b_valid, a_last, b_last}, 64'd0);
      chk("midrst_word", {a_word, b_word}, 64'd0);
      chk("midrst_accept_held", {63'd0, a_accept}, 64'd0);
      reset = 1'b0;
      tick(1);
      chk("postrst_accept", {62'd0, a_accept, b_accept}, 64'd3);
      capture(mk(1));
      chk("restart_word", {a_word, b_word}, {32'hDEAD0000, 32'hDEAD0000});
      chk("restart_rc", {56'd0, a_row, a_col, b_row, b_col}, 64'd0);
      tick(16);
      chk("restart_done", {62'd0, a_accept, a_valid}, 64'd2);
      chk("final_drained", {32'(q_a.size()), 32'(q_b.size())}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
